// File: rtl/dft_pkg.sv
// Shared definitions for the dft_block datapath, its frame controller and their benches.
package dft_pkg;

   // Frame controller phases: gather samples, wait for the transform, stream results.
   typedef enum logic [1:0] {
      LOAD    = 2'd0,
      COMPUTE = 2'd1,
      DRAIN   = 2'd2
   } dft_ctrl_state_t;

   localparam int unsigned DFT_N_DEFAULT       = 2;
   localparam int unsigned DFT_WORD_SZ_DEFAULT = 8;
   localparam int unsigned DFT_LAT_DEFAULT     = 1;
   localparam int unsigned DFT_CNT_W_DEFAULT   = 16;

   // Bits needed to index n items; never narrower than one bit.
   function automatic int unsigned idx_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/dft_frame_unpack.sv
// Result side of the frame controller: holds the captured transform output and
// streams it out one word at a time over a valid/ready handshake.
module dft_frame_unpack
   import dft_pkg::*;
#(
   parameter int unsigned N       = DFT_N_DEFAULT,
   parameter int unsigned WORD_SZ = DFT_WORD_SZ_DEFAULT
) (
   input  logic                 i_CLK,
   input  logic                 i_RESET,
   input  logic                 i_load,
   input  logic [N*WORD_SZ-1:0] i_result,
   input  logic                 i_active,
   input  logic                 i_flush,
   input  logic                 i_out_ready,
   output logic                 o_out_valid,
   output logic [WORD_SZ-1:0]   o_out,
   output logic                 o_out_last,
   output logic                 o_done
);

   localparam int unsigned     IdxW    = idx_width(N);
   localparam logic [IdxW-1:0] LastIdx = IdxW'(N - 1);

   logic [N*WORD_SZ-1:0] buf_q, buf_d;
   logic [IdxW-1:0]      drain_idx_q, drain_idx_d;
   logic [WORD_SZ-1:0]   word;
   logic                 is_last;
   logic                 out_hs;

   assign is_last = (drain_idx_q == LastIdx);
   // A word handshaking alongside a flush is not delivered.
   assign out_hs  = i_active & i_out_ready & ~i_flush;
   assign o_done  = out_hs & is_last;

   // Select the word addressed by the drain index.
   always_comb begin
      word = '0;
      for (int k = 0; k < N; k++) begin
         if (drain_idx_q == IdxW'(k)) begin
            word = buf_q[k*WORD_SZ +: WORD_SZ];
         end
      end
   end

   // Outputs are gated by the registered active flag so they read 0 outside DRAIN.
   always_comb begin
      o_out_valid = i_active;
      o_out       = i_active ? word : '0;
      o_out_last  = i_active & is_last;
   end

   // Next-state for the result buffer and drain index.
   always_comb begin
      buf_d       = buf_q;
      drain_idx_d = drain_idx_q;
      if (i_load) begin
         buf_d       = i_result;
         drain_idx_d = '0;
      end else if (i_flush) begin
         drain_idx_d = '0;
      end else if (out_hs) begin
         drain_idx_d = is_last ? '0 : drain_idx_q + 1'b1;
      end
   end

   // Result buffer and drain index registers, synchronous active-low reset.
   always_ff @(posedge i_CLK) begin
      if (!i_RESET) begin
         buf_q       <= '0;
         drain_idx_q <= '0;
      end else begin
         buf_q       <= buf_d;
         drain_idx_q <= drain_idx_d;
      end
   end

endmodule

// File: rtl/dft_frame_ctrl.sv
// Frame sequencer for dft_block: packs N samples into a frame, holds it for the
// transform latency, captures the result and hands it to the unpacker.
module dft_frame_ctrl
   import dft_pkg::*;
#(
   parameter int unsigned N       = DFT_N_DEFAULT,
   parameter int unsigned WORD_SZ = DFT_WORD_SZ_DEFAULT,
   parameter int unsigned DFT_LAT = DFT_LAT_DEFAULT,
   parameter int unsigned CNT_W   = DFT_CNT_W_DEFAULT
) (
   input  logic                 i_CLK,
   input  logic                 i_RESET,
   input  logic                 i_sample_valid,
   input  logic [WORD_SZ-1:0]   i_sample,
   output logic                 o_sample_ready,
   output logic [N*WORD_SZ-1:0] o_frame,
   input  logic [N*WORD_SZ-1:0] i_result,
   output logic                 o_out_valid,
   output logic [WORD_SZ-1:0]   o_out,
   output logic                 o_out_last,
   input  logic                 i_out_ready,
   input  logic                 i_abort,
   output logic                 o_busy,
   output logic [CNT_W-1:0]     o_frame_count
);

   localparam int unsigned      IdxW     = idx_width(N);
   localparam int unsigned      WaitW    = idx_width(DFT_LAT + 2);
   localparam logic [IdxW-1:0]  LastIdx  = IdxW'(N - 1);
   localparam logic [WaitW-1:0] WaitLast = WaitW'(DFT_LAT);

   dft_ctrl_state_t      state_q, state_d;
   logic [IdxW-1:0]      load_idx_q, load_idx_d;
   logic [WaitW-1:0]     wait_q, wait_d;
   logic [N*WORD_SZ-1:0] frame_q, frame_d;
   logic [CNT_W-1:0]     frame_cnt_q, frame_cnt_d;
   logic                 ready_q, ready_d;

   logic sample_hs;
   logic capture;
   logic flush;
   logic drain_done;

   // ready_q is only set in LOAD, so it alone qualifies the sample handshake.
   assign sample_hs = ready_q & i_sample_valid;
   assign flush     = i_abort & (state_q != LOAD);
   assign capture   = (state_q == COMPUTE) & ~i_abort & (wait_q == WaitLast);
   // Registered so ready stays low for the first cycle after reset.
   assign ready_d   = (state_d == LOAD);

   // Next-state logic for the FSM, load index, wait counter, frame and frame count.
   always_comb begin
      state_d     = state_q;
      load_idx_d  = load_idx_q;
      wait_d      = wait_q;
      frame_d     = frame_q;
      frame_cnt_d = frame_cnt_q;
      unique case (state_q)
         LOAD: begin
            if (i_abort) begin
               load_idx_d = '0;
            end else if (sample_hs) begin
               for (int k = 0; k < N; k++) begin
                  if (load_idx_q == IdxW'(k)) begin
                     frame_d[k*WORD_SZ +: WORD_SZ] = i_sample;
                  end
               end
               if (load_idx_q == LastIdx) begin
                  load_idx_d = '0;
                  wait_d     = '0;
                  state_d    = COMPUTE;
               end else begin
                  load_idx_d = load_idx_q + 1'b1;
               end
            end
         end
         COMPUTE: begin
            if (flush) begin
               state_d = LOAD;
            end else if (capture) begin
               state_d = DRAIN;
            end else begin
               wait_d = wait_q + 1'b1;
            end
         end
         DRAIN: begin
            if (flush) begin
               state_d = LOAD;
            end else if (drain_done) begin
               state_d     = LOAD;
               frame_cnt_d = frame_cnt_q + 1'b1;
            end
         end
         default: begin
            state_d = LOAD;
         end
      endcase
   end

   // Control registers, synchronous active-low reset from any state.
   always_ff @(posedge i_CLK) begin
      if (!i_RESET) begin
         state_q     <= LOAD;
         load_idx_q  <= '0;
         wait_q      <= '0;
         frame_q     <= '0;
         frame_cnt_q <= '0;
         ready_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         load_idx_q  <= load_idx_d;
         wait_q      <= wait_d;
         frame_q     <= frame_d;
         frame_cnt_q <= frame_cnt_d;
         ready_q     <= ready_d;
      end
   end

   dft_frame_unpack #(
      .N       (N),
      .WORD_SZ (WORD_SZ)
   ) u_unpack (
      .i_CLK       (i_CLK),
      .i_RESET     (i_RESET),
      .i_load      (capture),
      .i_result    (i_result),
      .i_active    (state_q == DRAIN),
      .i_flush     (flush),
      .i_out_ready (i_out_ready),
      .o_out_valid (o_out_valid),
      .o_out       (o_out),
      .o_out_last  (o_out_last),
      .o_done      (drain_done)
   );

   assign o_sample_ready = ready_q;
   assign o_frame        = frame_q;
   assign o_busy         = (state_q != LOAD);
   assign o_frame_count  = frame_cnt_q;

endmodule
